// File: rtl/id_pkg.sv
// id_pkg: shared decode-stage constants and memory-op encodings for id_regfile_sb.
package id_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_REG   = 0;

    typedef enum logic [1:0] {
        MEM_NONE     = 2'd0,
        MEM_WORD     = 2'd1,
        MEM_HALFWORD = 2'd2,
        MEM_BYTE     = 2'd3
    } mem_e;

    function automatic logic is_load(mem_e op);
        return op != MEM_NONE;
    endfunction
endpackage

// File: rtl/id_regfile_sb_if.sv
// id_regfile_sb_if: operand read, WB write and issue/flush signals between ID control and the regfile.
interface id_regfile_sb_if import id_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
    logic [NUM_RD-1:0]        rd_valid_i;
    logic [NUM_RD*DATA_W-1:0] rd_data_o;
    logic                     wr_en_i;
    logic [ADDR_W-1:0]        wr_addr_i;
    logic [DATA_W-1:0]        wr_data_i;
    logic                     issue_i;
    logic                     issue_load_i;
    logic [ADDR_W-1:0]        issue_dst_i;
    logic                     flush_i;
    logic                     stall_o;
    logic                     sb_busy_o;

    modport master (
        output rd_addr_i, rd_valid_i, wr_en_i, wr_addr_i, wr_data_i,
               issue_i, issue_load_i, issue_dst_i, flush_i,
        input  rd_data_o, stall_o, sb_busy_o
    );

    modport slave (
        input  rd_addr_i, rd_valid_i, wr_en_i, wr_addr_i, wr_data_i,
               issue_i, issue_load_i, issue_dst_i, flush_i,
        output rd_data_o, stall_o, sb_busy_o
    );
endinterface

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register load-pending down-counters with load-use stall and busy reduction.
module id_scoreboard import id_pkg::*; #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk_i,
    input  logic                     n_rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    input  logic [NUM_RD-1:0]        rd_valid,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic                     issue,
    input  logic                     issue_load,
    input  logic [ADDR_W-1:0]        issue_dst,
    input  logic                     flush,
    output logic                     stall,
    output logic                     busy
);
    localparam int NREGS = 2**ADDR_W;
    localparam int CNT_W = $clog2(LOAD_LAT+1);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [CNT_W-1:0] nxt [NREGS];
    logic             arm;

    // stall gates issue, so a stalled load never re-arms its own entry
    assign arm = issue && !stall && !flush && issue_load && issue_dst != ADDR_W'(ZERO_REG);

    always_comb begin
        for (int i = 0; i < NREGS; i++)
            nxt[i] = flush                               ? '0 :
                     (arm && issue_dst == ADDR_W'(i))    ? CNT_W'(LOAD_LAT) :
                     (wr_en && wr_addr == ADDR_W'(i))    ? '0 :
                     (cnt[i] != '0)                      ? cnt[i] - CNT_W'(1) : '0;
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        else
            for (int i = 0; i < NREGS; i++) cnt[i] <= nxt[i];
    end

    always_comb begin
        stall = 1'b0;
        busy  = 1'b0;
        for (int k = 0; k < NUM_RD; k++)
            stall = stall || (rd_valid[k] && rd_addr[k*ADDR_W +: ADDR_W] != ADDR_W'(ZERO_REG)
                              && cnt[rd_addr[k*ADDR_W +: ADDR_W]] != '0);
        for (int i = 0; i < NREGS; i++)
            busy = busy || cnt[i] != '0;
    end
endmodule

// File: rtl/id_regfile_sb.sv
// id_regfile_sb: decode-stage register file (r0 hard-wired to zero) with load-use scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle WB write to matching read ports.
module id_regfile_sb import id_pkg::*; #(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int LOAD_LAT = 1
) (
    input logic            clk_i,
    input logic            n_rst_i,
    id_regfile_sb_if.slave bus
);
    localparam int NREGS = 2**ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_ok;

    assign wr_ok = bus.wr_en_i && bus.wr_addr_i != ADDR_W'(ZERO_REG);

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i)
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (wr_ok)
            regs[bus.wr_addr_i] <= bus.wr_data_i;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = bus.rd_addr_i[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
        assign bus.rd_data_o[k*DATA_W +: DATA_W] = (wr_ok && a == bus.wr_addr_i) ? bus.wr_data_i : regs[a];
`else
        assign bus.rd_data_o[k*DATA_W +: DATA_W] = regs[a];
`endif
    end

    id_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .LOAD_LAT(LOAD_LAT)
    ) u_sb (
        .clk_i     (clk_i),
        .n_rst_i   (n_rst_i),
        .rd_addr   (bus.rd_addr_i),
        .rd_valid  (bus.rd_valid_i),
        .wr_en     (bus.wr_en_i),
        .wr_addr   (bus.wr_addr_i),
        .issue     (bus.issue_i),
        .issue_load(bus.issue_load_i),
        .issue_dst (bus.issue_dst_i),
        .flush     (bus.flush_i),
        .stall     (bus.stall_o),
        .busy      (bus.sb_busy_o)
    );
endmodule

// File: tb/tb_id_regfile_sb.sv
// tb_id_regfile_sb: directed checks of id_regfile_sb with NUM_RD = 3, LOAD_LAT = 3.
module tb_id_regfile_sb;
    import id_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    id_regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) bus ();

    id_regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .LOAD_LAT(3)) dut (
        .clk_i  (clk),
        .n_rst_i(rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input logic [4:0] a0, a1, a2, input logic [2:0] v);
        bus.rd_addr_i  = {a2, a1, a0};
        bus.rd_valid_i = v;
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = a;
        bus.wr_data_i = d;
        tick();
        bus.wr_en_i = 1'b0;
    endtask

    task automatic set_issue(input logic en, input mem_e op, input logic [4:0] dst);
        bus.issue_i      = en;
        bus.issue_load_i = is_load(op);
        bus.issue_dst_i  = dst;
    endtask

    function automatic logic [31:0] rd(input int k);
        logic [95:0] all;
        all = bus.rd_data_o;
        return all[k*32 +: 32];
    endfunction

    initial begin
        bus.rd_addr_i = '0; bus.rd_valid_i = '0;
        bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0;
        set_issue(1'b0, MEM_NONE, 5'd0);
        bus.flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("rst_busy", {31'd0, bus.sb_busy_o}, 32'd0);
        set_rd(5'd5, 5'd9, 5'd31, 3'b000);
        chk("rst_rd0", rd(0), 32'd0);
        chk("rst_rd2", rd(2), 32'd0);

        // async reset mid-stall clears data and scoreboard immediately
        tick();
        wr(5'd5, 32'hDEADBEEF);
        chk("wr_r5", rd(0), 32'hDEADBEEF);
        set_issue(1'b1, MEM_WORD, 5'd7);
        tick();
        set_issue(1'b0, MEM_NONE, 5'd0);
        set_rd(5'd5, 5'd7, 5'd0, 3'b010);
        chk("pre_rst_stall", {31'd0, bus.stall_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_r5", rd(0), 32'd0);
        chk("arst_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("arst_busy", {31'd0, bus.sb_busy_o}, 32'd0);
        #2 rst_n = 1'b1;

        // r0 stays zero
        tick();
        wr(5'd0, 32'h1234);
        set_rd(5'd0, 5'd0, 5'd0, 3'b111);
        chk("zero_p0", rd(0), 32'd0);
        chk("zero_p1", rd(1), 32'd0);
        chk("zero_p2", rd(2), 32'd0);
        chk("zero_nostall", {31'd0, bus.stall_o}, 32'd0);

        // load-use with L=3; issue held so the stalled re-issue must wait
        set_rd(5'd7, 5'd0, 5'd0, 3'b001);
        set_issue(1'b1, MEM_HALFWORD, 5'd7);
        tick();
        chk("lu_t1", {31'd0, bus.stall_o}, 32'd1);
        chk("lu_busy", {31'd0, bus.sb_busy_o}, 32'd1);
        tick();
        chk("lu_t2", {31'd0, bus.stall_o}, 32'd1);
        tick();
        chk("lu_t3", {31'd0, bus.stall_o}, 32'd1);
        tick();
        chk("lu_t4", {31'd0, bus.stall_o}, 32'd0);
        tick();
        set_issue(1'b0, MEM_NONE, 5'd0);
        #1;
        chk("lu_rearm", {31'd0, bus.stall_o}, 32'd1);
        set_rd(5'd7, 5'd0, 5'd0, 3'b000);
        chk("lu_novalid1", {31'd0, bus.stall_o}, 32'd0);
        tick();
        chk("lu_novalid2", {31'd0, bus.stall_o}, 32'd0);
        chk("lu_busy2", {31'd0, bus.sb_busy_o}, 32'd1);
        tick();
        tick();
        chk("lu_idle", {31'd0, bus.sb_busy_o}, 32'd0);

        // early completion by WB write
        set_issue(1'b1, MEM_BYTE, 5'd9);
        tick();
        set_issue(1'b0, MEM_NONE, 5'd0);
        set_rd(5'd9, 5'd0, 5'd0, 3'b001);
        chk("ec_stall", {31'd0, bus.stall_o}, 32'd1);
        wr(5'd9, 32'h0000_0099);
        chk("ec_clear", {31'd0, bus.stall_o}, 32'd0);
        chk("ec_busy", {31'd0, bus.sb_busy_o}, 32'd0);
        chk("ec_data", rd(0), 32'h0000_0099);

        // flush kills pending hazard
        set_issue(1'b1, MEM_WORD, 5'd9);
        tick();
        set_issue(1'b0, MEM_NONE, 5'd0);
        bus.flush_i = 1'b1;
        #1;
        chk("fl_stall_pre", {31'd0, bus.stall_o}, 32'd1);
        tick();
        bus.flush_i = 1'b0;
        #1;
        chk("fl_stall", {31'd0, bus.stall_o}, 32'd0);
        chk("fl_busy", {31'd0, bus.sb_busy_o}, 32'd0);

        // flush wins over same-cycle issue
        set_issue(1'b1, MEM_WORD, 5'd9);
        bus.flush_i = 1'b1;
        tick();
        set_issue(1'b0, MEM_NONE, 5'd0);
        bus.flush_i = 1'b0;
        #1;
        chk("fl_issue_busy", {31'd0, bus.sb_busy_o}, 32'd0);

        // non-load issue does not arm
        set_issue(1'b1, MEM_NONE, 5'd9);
        tick();
        set_issue(1'b0, MEM_NONE, 5'd0);
        #1;
        chk("nonload_busy", {31'd0, bus.sb_busy_o}, 32'd0);

        // same-cycle write/read on r3
        wr(5'd3, 32'h1111_1111);
        set_rd(5'd0, 5'd3, 5'd0, 3'b000);
        bus.wr_en_i = 1'b1; bus.wr_addr_i = 5'd3; bus.wr_data_i = 32'hA5A5A5A5;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_same", rd(1), 32'hA5A5A5A5);
`else
        chk("byp_same", rd(1), 32'h1111_1111);
`endif
        tick();
        bus.wr_en_i = 1'b0;
        #1;
        chk("byp_next", rd(1), 32'hA5A5A5A5);

        // multi-port hazard mask
        set_issue(1'b1, MEM_WORD, 5'd4);
        tick();
        set_issue(1'b0, MEM_NONE, 5'd0);
        set_rd(5'd1, 5'd4, 5'd4, 3'b101);
        chk("mp_101", {31'd0, bus.stall_o}, 32'd1);
        set_rd(5'd1, 5'd4, 5'd4, 3'b001);
        chk("mp_001", {31'd0, bus.stall_o}, 32'd0);
        set_rd(5'd1, 5'd4, 5'd4, 3'b010);
        chk("mp_010", {31'd0, bus.stall_o}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_regfile_sb.md
# id_regfile_sb

Parametrised register file with an integrated load-use scoreboard for the decode stage. It is the next generation of the decode-stage register file and hazard check. Relative to the current design it adds:
- a configurable number of read ports;
- synchronous posedge writes;
- a hard-wired zero register;
- multi-cycle load latency tracking;
- pipeline flush of pending hazards;
- optional write-to-read bypass.

It sits in ID: the operand addresses come from IF/ID, the write port is driven by WB, and `stall_o` feeds the IF/ID hold and the ID/EX bubble insertion.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; NREGS = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- LOAD_LAT, 1, cycles a load destination stays pending after issue (1..7)

- clk_i  in  1  clock; all state updates on posedge
- n_rst_i  in  1  asynchronous active-low reset
- rd_addr_i  in  NUM_RD*ADDR_W  read addresses; port k at [k*ADDR_W +: ADDR_W]
- rd_valid_i  in  NUM_RD  port k actually uses its operand (hazard mask)
- rd_data_o  out  NUM_RD*DATA_W  read data; port k at [k*DATA_W +: DATA_W]
- wr_en_i  in  1  WB write enable
- wr_addr_i  in  ADDR_W  WB write address
- wr_data_i  in  DATA_W  WB write data
- issue_i  in  1  the ID instruction advances this cycle
- issue_load_i  in  1  the advancing instruction is a load (word/half/byte)
- issue_dst_i  in  ADDR_W  destination register of the advancing load
- flush_i  in  1  branch/jump flush; kills all pending hazards
- stall_o  out  1  load-use stall request
- sb_busy_o  out  1  at least one scoreboard entry is non-zero

## Operation
- **Storage:** NREGS x DATA_W array.
  - Register 0 always reads 0; writes to it are dropped.
- **Write:** on posedge, when wr_en_i && wr_addr_i != 0, store wr_data_i at wr_addr_i.
- **Read:** combinational, rd_data_o[k] = regs[rd_addr_i[k]].
  - Multiple ports may read the same address.
- **Scoreboard:** one counter per register, width $clog2(LOAD_LAT+1), all reset to 0.
- **Effective issue:** eff_issue = issue_i && !stall_o && !flush_i.
- **Per-cycle counter update, in priority order:**
  1. flush_i: all counters <= 0.
  2. eff_issue && issue_load_i && issue_dst_i != 0: cnt[issue_dst_i] <= LOAD_LAT. This overrides the decrement and the write-clear on that entry.
  3. wr_en_i && cnt[wr_addr_i] != 0: cnt[wr_addr_i] <= 0 (early completion).
  4. Otherwise, every non-zero counter decrements by 1.
- **Stall:** stall_o = OR over k of (rd_valid_i[k] && rd_addr_i[k] != 0 && cnt[rd_addr_i[k]] != 0).
  - Purely combinational; never depends on issue_i in the same cycle.
- **Busy:** sb_busy_o = OR of all counters != 0.
- **State machine:** none beyond the per-register down-counters. Each entry is IDLE (0) or PENDING (1..LOAD_LAT).

## Timing
- **Reset (async assert, sync release):** all registers 0, all counters 0, stall_o = 0, sb_busy_o = 0, rd_data_o = 0.
- **Write latency:** a write at posedge T is visible on rd_data_o after T. Same-cycle visibility is covered under Configuration.
- **Stall window:** a load issued at posedge T with LOAD_LAT = L keeps a dependent read stalled in cycles T+1 .. T+L; stall_o drops in cycle T+L+1. With L = 1 this gives exactly one bubble.
- **Back-to-back load:** if cycle T+1 has a dependent load to the same destination, it stalls and is not re-armed until it issues.
- **Independent load during a stall:** it is not issued, because eff_issue is gated by stall_o.
- **Flush and issue in the same cycle:** flush wins; the counter stays 0.
- **Reset mid-stall:** counters are cleared immediately; stall_o drops asynchronously.
- **Counter saturation:** not possible, since re-arm always loads LOAD_LAT.

## Configuration
- **REGFILE_BYPASS_EN defined:** when wr_en_i && wr_addr_i != 0 && rd_addr_i[k] == wr_addr_i, rd_data_o[k] = wr_data_i in the same cycle. Write-then-read in one cycle returns the new value.
- **Not defined:** reads return the pre-write value in the write cycle; the new value appears the next cycle. The pipeline then needs an extra WB-to-ID forwarding path.

## Structure
- **Shared package id_pkg holds:**
  - DATA_W and ADDR_W defaults;
  - the MEM_NONE/WORD/HALFWORD/BYTE encodings used to derive issue_load_i;
  - the constant ZERO_REG = 0.
- **Sub-module id_scoreboard:** the counter array plus the stall/busy reduction.
  - Parameters: ADDR_W, NUM_RD, LOAD_LAT.
  - The storage array and bypass stay in the top.

## Test plan
- **Reset:** write 0xDEADBEEF to r5, then pulse n_rst_i low mid-cycle -> rd_data_o for r5 = 0, stall_o = 0 immediately, sb_busy_o = 0.
- **Zero register:** write 0x1234 to r0; read r0 on all ports -> 0.
- **Load-use, LOAD_LAT = 3:** issue load to r7 at T; read r7 with rd_valid_i = 1 -> stall_o = 1 in T+1..T+3, 0 in T+4. With rd_valid_i = 0 -> stall_o = 0 throughout.
- **Early completion and flush:** load to r9 (L = 3), then a WB write to r9 at T+1 -> stall_o = 0 from T+2. Separately, flush_i at T+1 -> stall_o = 0 and sb_busy_o = 0 from T+2.
- **Bypass:** wr_en_i = 1, r3 = 0xA5A5A5A5 with rd_addr_i[1] = 3 in the same cycle -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without it.
- **Multi-port conflict, NUM_RD = 3:** pending load to r4; ports read r1, r4, r4 with rd_valid_i = 3'b101 -> stall_o = 1 (via port 2). With rd_valid_i = 3'b001 -> stall_o = 0.
